rs485_tx_arbiter: RTL

Shares the single RS485 UART transmitter between three byte sources (key events, receive echo, periodic status) and sequences the half-duplex line driver around each transmission. Sits between the requesting logic and the UART transmit core inside the RS485 key/LED path.
- Grants one byte at a time, round-robin.
- Drives the transceiver direction enable with lead/lag guard times.
- Pulses the UART start strobe and tracks its busy flag, including a timeout if the UART never responds.

---
 rtl/rs485_tx_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rs485_tx_arbiter.sv
// Shares one RS485 UART transmitter between three byte sources (round-robin)
// and sequences the half-duplex driver enable with lead/lag guard times.
module rs485_tx_arbiter #(
    parameter int GUARD_CYCLES = 16,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [2:0]  req_valid,
    input  logic [23:0] req_data,
    output logic [2:0]  req_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        rs485_de,
    output logic        tx_err
);

    localparam int CNT_MAX = (GUARD_CYCLES > BUSY_TIMEOUT) ? GUARD_CYCLES : BUSY_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] GUARD_END   = CNT_W'(GUARD_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(BUSY_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_LAG
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       last_q, last_d;
    logic [7:0]       data_q, data_d;
    logic             run_q;
    logic             start_q, start_d;
    logic             de_q, de_d;
    logic             err_q, err_d;

    logic             timeout;
    logic             arb_en;
    logic             granted;
    logic [2:0]       grant_oh;
    logic [1:0]       grant_idx;
    logic [7:0]       grant_byte;

    // A timed-out WAIT_BUSY behaves exactly like the busy-fall cycle of WAIT_DONE.
    assign timeout = (state_q == S_WAIT_BUSY) && (cnt_q == TIMEOUT_END);

    // run_q keeps grants off while reset is held and in the first cycle after it.
    assign arb_en = run_q && ((state_q == S_IDLE) || (state_q == S_LAG) ||
                              ((state_q == S_WAIT_DONE) && !tx_busy) || timeout);

    always_comb begin : arbitrate
        int idx;
        // NOTE: every variable written here gets a default first, so no path infers a latch.
        grant_oh   = 3'b000;
        grant_idx  = last_q;
        grant_byte = 8'h00;
        idx        = 0;
        for (int k = 1; k <= 3; k++) begin
            idx = (int'(last_q) + k) % 3;
            if (arb_en && req_valid[idx] && (grant_oh == 3'b000)) begin
                grant_oh[idx] = 1'b1;
                grant_idx     = 2'(idx);
                grant_byte    = req_data[8*idx +: 8];
            end
        end
    end

    assign granted = |grant_oh;
    assign last_d  = granted ? grant_idx : last_q;
    assign data_d  = granted ? grant_byte : data_q;

    always_comb begin : next_state
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (granted) begin
                    state_d = S_LEAD;
                    cnt_d   = CNT_ONE;
                end
            end
            S_LEAD: begin
                if (cnt_q == GUARD_END) state_d = S_START;
                else                    cnt_d   = cnt_q + CNT_ONE;
            end
            S_START: begin
                // A busy flag already high here is taken as the rise.
                cnt_d   = CNT_ONE;
                state_d = tx_busy ? S_WAIT_DONE : S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (timeout) begin
                    state_d = granted ? S_START : S_LAG;
                    cnt_d   = CNT_ONE;
                end else if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = granted ? S_START : S_LAG;
                    cnt_d   = CNT_ONE;
                end
            end
            S_LAG: begin
                if (granted)                 state_d = S_START;
                else if (cnt_q == GUARD_END) state_d = S_IDLE;
                else                         cnt_d   = cnt_q + CNT_ONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin : outputs
        de_d    = (state_d != S_IDLE);
        start_d = (state_d == S_START);
        err_d   = (state_d == S_WAIT_BUSY) && (cnt_d == TIMEOUT_END);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= 2'd2;
            data_q  <= 8'h00;
            run_q   <= 1'b0;
            start_q <= 1'b0;
            de_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            data_q  <= data_d;
            run_q   <= 1'b1;
            start_q <= start_d;
            de_q    <= de_d;
            err_q   <= err_d;
        end
    end

    // req_ready is decoded from the current request so the byte is consumed in
    // its grant cycle; every other output comes straight from a register.
    assign req_ready = grant_oh;
    assign tx_start  = start_q;
    assign tx_data   = data_q;
    assign rs485_de  = de_q;
    assign tx_err    = err_q;

endmodule
